// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the byte-enabled data memory.
package dmem_pkg;

  typedef enum logic {
    DMEM_CLEAR = 1'b0,
    DMEM_READY = 1'b1
  } dmem_state_e;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits below the word index.
  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// Post-reset clear sweep: walks every word once, then holds READY until the next reset.
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx
);

  dmem_state_e      state;
  logic [IDX_W-1:0] clr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DMEM_CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        DMEM_CLEAR: begin
          if (clr_ptr == IDX_W'(DEPTH - 1)) begin
            state <= DMEM_READY;
            ready <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        DMEM_READY: state <= DMEM_READY;
        default:    state <= DMEM_CLEAR;
      endcase
    end
  end

  // A reset cycle restarts the sweep, so it must not count as a cleared word.
  assign clr_we  = (state == DMEM_CLEAR) && !reset;
  assign clr_idx = clr_ptr;

endmodule

// File: rtl/data_memory_be.sv
// Word-organised, byte-addressed data memory with per-lane write enables and 1-cycle registered read.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                memread,
  input  logic                memwrite,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_valid,
  output logic                ready,
  output logic                access_err
);

  localparam int LANES  = lanes_of(DATA_W);
  localparam int LSB    = lsb_of(DATA_W);
  localparam int IDX_W  = idx_w_of(DEPTH);
  localparam int AIDX_W = ADDR_W - LSB;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_we;
  logic [IDX_W-1:0]  clr_idx;
  logic [AIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              misaligned;
  logic              in_range;
  logic              active;
  logic              req_ok;

  dmem_clear_ctrl #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_clear_ctrl (
    .clk    (clk),
    .reset  (reset),
    .ready  (ready),
    .clr_we (clr_we),
    .clr_idx(clr_idx)
  );

  assign word_idx = addr[ADDR_W-1:LSB];
  assign mem_idx  = word_idx[IDX_W-1:0];

  if (LSB > 0) begin : g_align
    assign misaligned = |addr[LSB-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

  assign in_range = 32'(word_idx) < 32'(DEPTH);
  assign active   = ready && !reset && (memread || memwrite);
  assign req_ok   = active && !misaligned && in_range;

  // NOTE: the array has no reset so it maps onto block RAM; the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (req_ok && memwrite) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) mem[mem_idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  // Same-edge read of the word being written returns the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      access_err <= 1'b0;
    end else begin
      read_valid <= req_ok && memread;
      access_err <= active && !req_ok;
      if (req_ok && memread) read_data <= mem[mem_idx];
    end
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Randomised + directed bench for data_memory_be: two instances (32x64 and 64x100) against array models.
module tb_data_memory_be;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: DATA_W=32, DEPTH=64, ADDR_W=9
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        a_rd, a_wr, a_rv, a_rdy, a_err;

  // Instance B: DATA_W=64, DEPTH=100, ADDR_W=10
  logic [9:0]  b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic [7:0]  b_be;
  logic        b_rd, b_wr, b_rv, b_rdy, b_err;

  data_memory_be #(.DATA_W(32), .DEPTH(64), .ADDR_W(9)) dut_a (
    .clk(clk), .reset(reset), .addr(a_addr), .write_data(a_wdata), .byte_en(a_be),
    .memread(a_rd), .memwrite(a_wr), .read_data(a_rdata), .read_valid(a_rv),
    .ready(a_rdy), .access_err(a_err)
  );

  data_memory_be #(.DATA_W(64), .DEPTH(100), .ADDR_W(10)) dut_b (
    .clk(clk), .reset(reset), .addr(b_addr), .write_data(b_wdata), .byte_en(b_be),
    .memread(b_rd), .memwrite(b_wr), .read_data(b_rdata), .read_valid(b_rv),
    .ready(b_rdy), .access_err(b_err)
  );

  int total = 0;
  int bad   = 0;
  logic checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural models ----------------
  logic [31:0] ma_mem [64];
  logic [63:0] mb_mem [100];
  int          a_left = 0, b_left = 0;
  logic [31:0] ea_rdata = '0;
  logic [63:0] eb_rdata = '0;
  logic        ea_rv = 1'b0, ea_err = 1'b0, ea_rdy = 1'b0;
  logic        eb_rv = 1'b0, eb_err = 1'b0, eb_rdy = 1'b0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be, input int lanes);
    logic [63:0] r = old;
    for (int i = 0; i < lanes; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // The model wipes everything at reset and simply stays deaf for DEPTH cycles.
  task automatic step_a();
    ea_rv  = 1'b0;
    ea_err = 1'b0;
    if (reset) begin
      ea_rdy = 1'b0; ea_rdata = '0; a_left = 64;
      foreach (ma_mem[i]) ma_mem[i] = '0;
    end else if (a_left > 0) begin
      a_left--;
      if (a_left == 0) ea_rdy = 1'b1;
    end else if (a_rd || a_wr) begin
      if ((int'(a_addr) % 4) != 0 || (int'(a_addr) / 4) >= 64) ea_err = 1'b1;
      else begin
        int idx = int'(a_addr) / 4;
        if (a_rd) begin ea_rdata = ma_mem[idx]; ea_rv = 1'b1; end
        if (a_wr) ma_mem[idx] = 32'(merge(64'(ma_mem[idx]), 64'(a_wdata), 8'(a_be), 4));
      end
    end
  endtask

  task automatic step_b();
    eb_rv  = 1'b0;
    eb_err = 1'b0;
    if (reset) begin
      eb_rdy = 1'b0; eb_rdata = '0; b_left = 100;
      foreach (mb_mem[i]) mb_mem[i] = '0;
    end else if (b_left > 0) begin
      b_left--;
      if (b_left == 0) eb_rdy = 1'b1;
    end else if (b_rd || b_wr) begin
      if ((int'(b_addr) % 8) != 0 || (int'(b_addr) / 8) >= 100) eb_err = 1'b1;
      else begin
        int idx = int'(b_addr) / 8;
        if (b_rd) begin eb_rdata = mb_mem[idx]; eb_rv = 1'b1; end
        if (b_wr) mb_mem[idx] = merge(mb_mem[idx], b_wdata, b_be, 8);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    step_a();
    step_b();
  end

  // Compare process: every output of both instances, every cycle.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("a_ready",      64'(a_rdy),   64'(ea_rdy));
      check("a_read_valid", 64'(a_rv),    64'(ea_rv));
      check("a_access_err", 64'(a_err),   64'(ea_err));
      check("a_read_data",  64'(a_rdata), 64'(ea_rdata));
      check("b_ready",      64'(b_rdy),   64'(eb_rdy));
      check("b_read_valid", 64'(b_rv),    64'(eb_rv));
      check("b_access_err", 64'(b_err),   64'(eb_err));
      check("b_read_data",  b_rdata,      eb_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
  endtask

  task automatic a_op(input logic rd, input logic wr, input logic [8:0] ad,
                      input logic [31:0] d, input logic [3:0] be);
    a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = d; a_be = be;
    @(negedge clk);
    idle_all();
  endtask

  task automatic b_op(input logic rd, input logic wr, input logic [9:0] ad,
                      input logic [63:0] d, input logic [7:0] be);
    b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = d; b_be = be;
    @(negedge clk);
    idle_all();
  endtask

  task automatic rand_a();
    int idx = $urandom_range(0, 67);
    int off = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
    a_rd = 1'($urandom_range(0, 1)); a_wr = 1'($urandom_range(0, 1));
    a_addr = 9'(idx * 4 + off); a_wdata = $urandom; a_be = 4'($urandom);
  endtask

  task automatic rand_b();
    int idx = $urandom_range(0, 103);
    int off = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0;
    b_rd = 1'($urandom_range(0, 1)); b_wr = 1'($urandom_range(0, 1));
    b_addr = 10'(idx * 8 + off); b_wdata = {$urandom, $urandom}; b_be = 8'($urandom);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts cycles with ready low after reset release; requests keep flowing while low.
  task automatic count_ready(output int ca, output int cb);
    ca = 0; cb = 0;
    for (int i = 0; i < 150; i++) begin
      if (!a_rdy) begin ca++; rand_a(); end else begin a_rd = 1'b0; a_wr = 1'b0; end
      if (!b_rdy) begin cb++; rand_b(); end else begin b_rd = 1'b0; b_wr = 1'b0; end
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic read_all_zero(input string tag);
    logic [63:0] acc_a = '0, acc_b = '0;
    for (int i = 0; i < 100; i++) begin
      a_rd = (i < 64); a_addr = 9'(i * 4);
      b_rd = 1'b1;     b_addr = 10'(i * 8);
      @(negedge clk);
      if (a_rv) acc_a |= 64'(a_rdata);
      if (b_rv) acc_b |= b_rdata;
    end
    idle_all();
    check({tag, "_a_all_zero"}, acc_a, 64'h0);
    check({tag, "_b_all_zero"}, acc_b, 64'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ca, cb;
    reset = 1'b1;
    a_addr = '0; a_wdata = '0; a_be = '0;
    b_addr = '0; b_wdata = '0; b_be = '0;
    idle_all();
    @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Clear sweep length after a 1-cycle reset, then every word reads zero.
    count_ready(ca, cb);
    check("sweep_len_a", 64'(ca), 64'd64);
    check("sweep_len_b", 64'(cb), 64'd100);
    check("model_ready_a", 64'(ea_rdy), 64'd1);
    read_all_zero("init");

    // Byte-lane merge.
    a_op(1'b0, 1'b1, 9'h10, 32'hDEADBEEF, 4'b1111);
    a_op(1'b0, 1'b1, 9'h10, 32'h11223344, 4'b0101);
    a_op(1'b1, 1'b0, 9'h10, 32'h0, 4'h0);
    check("merge_data",  64'(a_rdata),  64'hDE22BE44);
    check("merge_model", 64'(ea_rdata), 64'hDE22BE44);
    check("merge_valid", 64'(a_rv), 64'd1);
    @(negedge clk);
    check("valid_pulse", 64'(a_rv), 64'd0);

    // Misaligned / out-of-range accesses are dropped and flagged.
    a_op(1'b1, 1'b0, 9'h13, 32'h0, 4'h0);
    check("misalign_err",   64'(a_err),   64'd1);
    check("misalign_valid", 64'(a_rv),    64'd0);
    check("misalign_hold",  64'(a_rdata), 64'hDE22BE44);
    a_op(1'b1, 1'b0, 9'h100, 32'h0, 4'h0);
    check("range_err",  64'(a_err),   64'd1);
    check("range_hold", 64'(a_rdata), 64'hDE22BE44);
    a_op(1'b0, 1'b1, 9'h12, 32'hFFFFFFFF, 4'hF);
    a_op(1'b1, 1'b0, 9'h10, 32'h0, 4'h0);
    check("misalign_wr_dropped", 64'(a_rdata), 64'hDE22BE44);

    // Read-before-write on the same word.
    a_op(1'b0, 1'b1, 9'h14, 32'hA5A5A5A5, 4'hF);
    a_op(1'b1, 1'b1, 9'h14, 32'h0, 4'hF);
    check("rbw_old", 64'(a_rdata), 64'hA5A5A5A5);
    a_op(1'b1, 1'b0, 9'h14, 32'h0, 4'h0);
    check("rbw_new", 64'(a_rdata), 64'h0);

    // Wide instance: last word reachable, one past it rejected.
    b_op(1'b0, 1'b1, 10'd792, 64'h0123456789ABCDEF, 8'hFF);
    b_op(1'b1, 1'b0, 10'd792, 64'h0, 8'h0);
    check("b_idx99_data", b_rdata, 64'h0123456789ABCDEF);
    check("b_idx99_err",  64'(b_err), 64'd0);
    b_op(1'b1, 1'b0, 10'd800, 64'h0, 8'h0);
    check("b_idx100_err", 64'(b_err), 64'd1);

    // Random traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      rand_a();
      rand_b();
      @(negedge clk);
    end
    idle_all();

    // Reset mid-sweep restarts it from word 0.
    pulse_reset();
    for (int i = 0; i < 30; i++) begin
      rand_a();
      rand_b();
      @(negedge clk);
    end
    pulse_reset();
    count_ready(ca, cb);
    check("restart_len_a", 64'(ca), 64'd64);
    check("restart_len_b", 64'(cb), 64'd100);
    read_all_zero("restart");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
